tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/fifo_ram.sv | 26 ++
 rtl/tx_fifo.sv | 118 +++++++++++
 tb/tb_tx_fifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART-side blocks: FSM state encoding and
// a pointer-width helper for power-of-two buffers.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } tx_state_e;

  // Address width for a buffer of the given depth; a 1-entry buffer still needs one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Depth x W storage array: synchronous write, combinational read.
// Contents are deliberately not reset.
module fifo_ram #(
  parameter int W     = 8,
  parameter int Depth = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/tx_fifo.sv
// Transmit-side word buffer: circular store plus a three-state issue FSM
// that hands one word at a time to the serializer.
module tx_fifo
  import uart_pkg::*;
#(
  parameter int W      = 8,
  parameter int Depth  = 16,
  parameter int Wcount = $clog2(Depth) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [W-1:0]      IN,
  input  logic              WE,
  output logic              FULL,
  output logic              EMPTY,
  output logic [Wcount-1:0] LEVEL,
  output logic              OVF,
  output logic [W-1:0]      OUT,
  output logic              OE,
  input  logic              RDY,
  output tx_state_e         dbg_state
);

  localparam int PW = ptr_width(Depth);
  localparam logic [PW-1:0]     PTR_ONE  = PW'(1);
  localparam logic [Wcount-1:0] LVL_ONE  = Wcount'(1);
  localparam logic [Wcount-1:0] LVL_FULL = Wcount'(Depth);

  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [Wcount-1:0] level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              oe_q, oe_d;
  logic [W-1:0]      out_q, out_d;
  tx_state_e         state_q, state_d;
  logic [W-1:0]      rd_data;
  logic              push, pop;

  fifo_ram #(
    .W    (W),
    .Depth(Depth),
    .AW   (PW)
  ) u_ram (
    .clk  (CLK),
    .we   (push),
    .waddr(wp_q),
    .wdata(IN),
    .raddr(rp_q),
    .rdata(rd_data)
  );

  assign FULL  = (level_q == LVL_FULL);
  assign EMPTY = (level_q == '0);

  // Handshake: a pop happens only in IDLE with RDY high; OE then pulses for
  // exactly one cycle with OUT valid, and RDY is ignored through SEND and HOLD
  // so the transmitter's one-cycle RDY drop can never cause a second issue.
  assign push = WE && !FULL;
  assign pop  = (state_q == ST_IDLE) && !EMPTY && RDY;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    ovf_d   = ovf_q | (WE & FULL);
    oe_d    = 1'b0;
    out_d   = out_q;
    state_d = state_q;

    if (push) wp_d = wp_q + PTR_ONE;
    if (pop)  rp_d = rp_q + PTR_ONE;

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          out_d   = rd_data;
          oe_d    = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: state_d = ST_HOLD;
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      oe_q    <= 1'b0;
      out_q   <= '0;
      state_q <= ST_IDLE;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
      state_q <= state_d;
    end
  end

  assign LEVEL     = level_q;
  assign OVF       = ovf_q;
  assign OE        = oe_q;
  assign OUT       = out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tx_fifo.sv
// Bench for tx_fifo: a transmitter model drives RDY, writes push expected
// words into exp_q, and every OE pops and compares OUT.
module tb_tx_fifo;
  import uart_pkg::*;

  localparam int W = 8;
  localparam int DEPTH = 16;
  localparam int WC = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in_d = '0;
  logic          we = 1'b0;
  logic          full, empty, ovf, oe, rdy;
  logic [WC-1:0] level;
  logic [W-1:0]  out_w;
  tx_state_e     dbg_state;

  logic          tx_en = 1'b0;
  int            tx_delay = 0;
  int            busy = 0;
  logic          rdy_prev = 1'b0;
  logic          oe_prev = 1'b0;
  int            oe_cnt = 0;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q [$];

  tx_fifo #(.W(W), .Depth(DEPTH), .Wcount(WC)) dut (
    .CLK      (clk),
    .RST      (rst),
    .IN       (in_d),
    .WE       (we),
    .FULL     (full),
    .EMPTY    (empty),
    .LEVEL    (level),
    .OVF      (ovf),
    .OUT      (out_w),
    .OE       (oe),
    .RDY      (rdy),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Transmitter model: busy for tx_delay cycles after it sees OE.
  assign rdy = tx_en && (busy == 0);
  always @(posedge clk or posedge rst) begin
    if (rst) busy <= 0;
    else if (oe) busy <= tx_delay;
    else if (busy > 0) busy <= busy - 1;
  end

  always @(posedge clk) rdy_prev <= rdy;

  always @(negedge clk) begin
    if (!rst && oe) begin
      oe_cnt++;
      check("oe_width", 32'(oe_prev), 32'd0);
      check("oe_rdy", 32'(rdy_prev), 32'd1);
      if (exp_q.size() == 0) check("oe_unexpected", 32'(out_w), 32'hFFFF_FFFF);
      else check("out", 32'(out_w), 32'(exp_q.pop_front()));
    end
    oe_prev = oe;
  end

  task automatic write_word(input logic [W-1:0] d, input bit expect_accept);
    @(negedge clk);
    we = 1'b1;
    in_d = d;
    if (expect_accept) exp_q.push_back(d);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic write_burst(input int n, input logic [W-1:0] first);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      we = 1'b1;
      in_d = first + W'(i);
      exp_q.push_back(in_d);
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || dbg_state != ST_IDLE) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < limit), 32'd1);
    check("drain_level", 32'(level), 32'd0);
    check("drain_empty", 32'(empty), 32'd1);
  endtask

  initial begin
    int oe_snap;
    logic [W-1:0] d;

    // Reset then idle
    tx_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_out", 32'(out_w), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_no_oe", 32'(oe_cnt), 32'd0);
    check("idle_empty", 32'(empty), 32'd1);

    // Single word: counted after the write edge, issued after the next edge
    write_word(8'hA5, 1'b1);
    check("single_level1", 32'(level), 32'd1);
    check("single_oe_early", 32'(oe), 32'd0);
    @(negedge clk);
    check("single_oe", 32'(oe), 32'd1);
    check("single_out", 32'(out_w), 32'hA5);
    check("single_level0", 32'(level), 32'd0);
    @(negedge clk);
    check("single_oe_drop", 32'(oe), 32'd0);
    repeat (4) @(negedge clk);
    check("single_out_hold", 32'(out_w), 32'hA5);
    check("single_oe_cnt", 32'(oe_cnt), 32'd1);

    // Burst of 16 into a stalled transmitter, then slow drain
    tx_en = 1'b0;
    tx_delay = 100;
    write_burst(16, 8'h01);
    check("burst_full", 32'(full), 32'd1);
    check("burst_level", 32'(level), 32'd16);
    oe_snap = oe_cnt;
    tx_en = 1'b1;
    wait_drain(3000);
    check("burst_oe_cnt", 32'(oe_cnt - oe_snap), 32'd16);
    check("burst_no_ovf", 32'(ovf), 32'd0);
    repeat (110) @(negedge clk);

    // Overflow: 17th write is rejected and must never reach OUT
    tx_en = 1'b0;
    tx_delay = 0;
    write_burst(16, 8'h40);
    write_word(8'hFF, 1'b0);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_level", 32'(level), 32'd16);
    check("ovf_full", 32'(full), 32'd1);
    tx_en = 1'b1;
    wait_drain(200);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Simultaneous write and pop at level 5
    tx_en = 1'b0;
    write_burst(5, 8'h80);
    check("sim_level5", 32'(level), 32'd5);
    @(negedge clk);
    tx_en = 1'b1;
    tx_delay = 2;
    we = 1'b1;
    in_d = 8'h55;
    exp_q.push_back(8'h55);
    @(negedge clk);
    we = 1'b0;
    check("sim_oe", 32'(oe), 32'd1);
    check("sim_level", 32'(level), 32'd5);
    check("sim_empty", 32'(empty), 32'd0);

    // Wrap-around: 40 random words with random gaps, drained as they come
    tx_delay = 0;
    for (int i = 0; i < 40; i++) begin
      d = W'($urandom_range(0, 255));
      write_word(d, 1'b1);
      repeat ($urandom_range(2, 4)) @(negedge clk);
    end
    wait_drain(400);

    // Reset mid-stream while in SEND with level 7
    tx_en = 1'b0;
    write_burst(8, 8'hC0);
    tx_en = 1'b1;
    @(negedge clk);
    check("mid_state_send", 32'(dbg_state), 32'(ST_SEND));
    check("mid_level7", 32'(level), 32'd7);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_oe", 32'(oe), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    oe_snap = oe_cnt;
    repeat (10) @(negedge clk);
    check("mid_no_stale_oe", 32'(oe_cnt - oe_snap), 32'd0);
    write_word(8'h3C, 1'b1);
    wait_drain(50);
    check("mid_resume_cnt", 32'(oe_cnt - oe_snap), 32'd1);
    check("mid_resume_out", 32'(out_w), 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
